bit_balance_tracker: RTL



---
 rtl/bit_balance_pkg.sv | 42 ++++
 rtl/bb_popcount.sv | 16 +
 rtl/bit_balance_tracker.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/bit_balance_pkg.sv
// Shared helpers for the bit-balance tracker: width derivation, popcount and
// signed saturating add.
package bit_balance_pkg;

  localparam int unsigned POP_MAX_W = 64;

  function automatic int unsigned cnt_width(input int unsigned data_w);
    return $clog2(data_w + 1);
  endfunction

  function automatic int unsigned frm_width(input int unsigned frame_len,
                                            input int unsigned data_w);
    return $clog2(frame_len * data_w + 1);
  endfunction

  // Callers zero-extend narrower words to POP_MAX_W.
  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

  // Symmetric saturation to +/-(2^(w-1)-1); w must not exceed 32.
  function automatic int signed sat_add(input int signed a, input int signed b,
                                        input int unsigned w);
    longint signed sum;
    longint signed lim;
    sum = 64'(a) + 64'(b);
    lim = (64'sd1 <<< (w - 32'd1)) - 64'sd1;
    if (sum > lim) begin
      return 32'(lim);
    end
    if (sum < -lim) begin
      return 32'(-lim);
    end
    return 32'(sum);
  endfunction

endpackage

// File: rtl/bb_popcount.sv
// Combinational ones counter for a W-bit slice.
module bb_popcount
  import bit_balance_pkg::*;
#(
  parameter int unsigned W = 4,
  localparam int unsigned CW = cnt_width(W)
) (
  input  logic [W-1:0]  data,
  output logic [CW-1:0] count_c
);

  always_comb begin
    count_c = CW'(popcount(POP_MAX_W'(data)));
  end

endmodule

// File: rtl/bit_balance_tracker.sv
// Two-stage streaming popcount with saturating running disparity and
// per-frame ones totals / DC-balance verdict.
module bit_balance_tracker
  import bit_balance_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned DISP_W    = 12,
  localparam int unsigned CNT_W    = cnt_width(DATA_W),
  localparam int unsigned FRM_W    = frm_width(FRAME_LEN, DATA_W),
  localparam int unsigned LEN_W    = $clog2(FRAME_LEN + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CNT_W-1:0]         out_count,
  output logic signed [DISP_W-1:0] out_disparity,
  output logic                     out_last,
  output logic [FRM_W-1:0]         out_frame_ones,
  output logic                     out_balanced
);

  localparam int unsigned HALF_W   = DATA_W / 2;
  localparam int unsigned HCNT_W   = cnt_width(HALF_W);
  localparam int signed   DATA_W_S = DATA_W;

  logic [HCNT_W-1:0] lo_cnt_c;
  logic [HCNT_W-1:0] hi_cnt_c;

  bb_popcount #(.W(HALF_W)) u_pop_lo (
    .data    (in_data[HALF_W-1:0]),
    .count_c (lo_cnt_c)
  );

  bb_popcount #(.W(HALF_W)) u_pop_hi (
    .data    (in_data[DATA_W-1:HALF_W]),
    .count_c (hi_cnt_c)
  );

  logic              s1_valid_q,  s1_valid_d;
  logic [HCNT_W-1:0] s1_lo_q,     s1_lo_d;
  logic [HCNT_W-1:0] s1_hi_q,     s1_hi_d;
  logic              s1_last_q,   s1_last_d;
  logic [LEN_W-1:0]  s1_nwords_q, s1_nwords_d;
  logic [LEN_W-1:0]  wcnt_q,      wcnt_d;

  logic                     out_valid_q,      out_valid_d;
  logic [CNT_W-1:0]         out_count_q,      out_count_d;
  logic signed [DISP_W-1:0] disp_q,           disp_d;
  logic [FRM_W-1:0]         frame_acc_q,      frame_acc_d;
  logic                     out_last_q,       out_last_d;
  logic [FRM_W-1:0]         out_frame_ones_q, out_frame_ones_d;
  logic                     out_balanced_q,   out_balanced_d;

  logic s2_adv_c;
  logic s1_adv_c;
  logic in_xfer_c;
  logic last_flag_c;

  // Handshake: in_ready depends only on registered state and out_ready.
  always_comb begin
    s2_adv_c  = !out_valid_q || out_ready;
    s1_adv_c  = s1_valid_q && s2_adv_c;
    in_ready  = !reset && (!s1_valid_q || s2_adv_c);
    in_xfer_c = in_valid && in_ready;
  end

  // S1: half popcounts, frame-close flag and word position within the frame.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_lo_d     = s1_lo_q;
    s1_hi_d     = s1_hi_q;
    s1_last_d   = s1_last_q;
    s1_nwords_d = s1_nwords_q;
    wcnt_d      = wcnt_q;
    last_flag_c = in_last || (wcnt_q == LEN_W'(FRAME_LEN - 1));
    if (in_xfer_c) begin
      s1_valid_d  = 1'b1;
      s1_lo_d     = lo_cnt_c;
      s1_hi_d     = hi_cnt_c;
      s1_last_d   = last_flag_c;
      s1_nwords_d = wcnt_q + LEN_W'(1);
      wcnt_d      = last_flag_c ? '0 : wcnt_q + LEN_W'(1);
    end else if (s1_adv_c) begin
      s1_valid_d = 1'b0;
    end
  end

  logic [CNT_W-1:0]         count_c;
  logic [FRM_W-1:0]         frame_next_c;
  logic signed [DISP_W-1:0] disp_next_c;
  logic                     balanced_c;
  int signed                cnt_i;
  int signed                disp_i;

  // S2: word count, disparity update and frame verdict.
  always_comb begin
    count_c      = CNT_W'(s1_lo_q) + CNT_W'(s1_hi_q);
    frame_next_c = frame_acc_q + FRM_W'(count_c);
    cnt_i        = 32'(count_c);
    disp_i       = 32'(disp_q);
    disp_next_c  = DISP_W'(sat_add(disp_i, 2 * cnt_i - DATA_W_S, DISP_W));
    balanced_c   = ((32'(frame_next_c) << 1) == 32'(s1_nwords_q) * DATA_W);

    out_valid_d      = out_valid_q;
    out_count_d      = out_count_q;
    disp_d           = disp_q;
    frame_acc_d      = frame_acc_q;
    out_last_d       = out_last_q;
    out_frame_ones_d = out_frame_ones_q;
    out_balanced_d   = out_balanced_q;
    if (s1_adv_c) begin
      out_valid_d = 1'b1;
      out_count_d = count_c;
      disp_d      = disp_next_c;
      out_last_d  = s1_last_q;
      if (s1_last_q) begin
        out_frame_ones_d = frame_next_c;
        out_balanced_d   = balanced_c;
        frame_acc_d      = '0;
      end else begin
        out_frame_ones_d = '0;
        out_balanced_d   = 1'b0;
        frame_acc_d      = frame_next_c;
      end
    end else if (s2_adv_c) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q       <= 1'b0;
      s1_lo_q          <= '0;
      s1_hi_q          <= '0;
      s1_last_q        <= 1'b0;
      s1_nwords_q      <= '0;
      wcnt_q           <= '0;
      out_valid_q      <= 1'b0;
      out_count_q      <= '0;
      disp_q           <= '0;
      frame_acc_q      <= '0;
      out_last_q       <= 1'b0;
      out_frame_ones_q <= '0;
      out_balanced_q   <= 1'b0;
    end else begin
      s1_valid_q       <= s1_valid_d;
      s1_lo_q          <= s1_lo_d;
      s1_hi_q          <= s1_hi_d;
      s1_last_q        <= s1_last_d;
      s1_nwords_q      <= s1_nwords_d;
      wcnt_q           <= wcnt_d;
      out_valid_q      <= out_valid_d;
      out_count_q      <= out_count_d;
      disp_q           <= disp_d;
      frame_acc_q      <= frame_acc_d;
      out_last_q       <= out_last_d;
      out_frame_ones_q <= out_frame_ones_d;
      out_balanced_q   <= out_balanced_d;
    end
  end

  always_comb begin
    out_valid      = out_valid_q;
    out_count      = out_count_q;
    out_disparity  = disp_q;
    out_last       = out_last_q;
    out_frame_ones = out_frame_ones_q;
    out_balanced   = out_balanced_q;
  end

endmodule
